// File: rtl/alu_top_pkg.sv
// Shared constants for the 8-bit demo ALU: opcodes, widths, 7-segment and anode patterns.
package alu_top_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned AN_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_NOT = 3'd5;
    localparam logic [OP_W-1:0] OP_SHL = 3'd6;
    localparam logic [OP_W-1:0] OP_SHR = 3'd7;

    // Active-low {g,f,e,d,c,b,a}; element 0 is the glyph for hex 0.
    localparam logic [15:0][SEG_W-1:0] SEG_HEX = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    // Active-low anode for each digit select; element 0 is digit0.
    localparam logic [3:0][AN_W-1:0] AN_PAT = {
        4'b0111, 4'b1011, 4'b1101, 4'b1110
    };

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex digit to active-low 7-segment pattern.
module seven_seg_decoder
    import alu_top_pkg::*;
(
    input  logic [3:0]       hex_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_HEX[hex_i];
    end

endmodule

// File: rtl/alu_top.sv
// Board-level 8-bit ALU: button-loaded operands/opcode, registered result on LEDs, 4-digit display.
// Optional ALU_DEBOUNCE_EN adds a per-button stable-level debounce ahead of edge detection.
module alu_top
    import alu_top_pkg::*;
#(
    parameter int unsigned REFRESH_BITS    = 18
`ifdef ALU_DEBOUNCE_EN
    ,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
`endif
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              pb_a,
    input  logic              pb_b,
    input  logic              pb_op,
    input  logic [DATA_W-1:0] sw,
    output logic [DATA_W-1:0] LED,
    output logic [AN_W-1:0]   AN_SEL,
    output logic [SEG_W-1:0]  seven_seg_out
);

    localparam int unsigned NBTN   = 3;
    localparam int unsigned BTN_A  = 0;
    localparam int unsigned BTN_B  = 1;
    localparam int unsigned BTN_OP = 2;

    logic [NBTN-1:0]         sync1_q, sync2_q, lvl_prev_q;
    logic [NBTN-1:0]         btn_lvl, btn_rise;
    logic [DATA_W-1:0]       a_q, a_d, b_q, b_d, result_q, result_d;
    logic [OP_W-1:0]         op_q, op_d;
    logic                    carry_q, carry_d;
    logic [DATA_W:0]         alu_wide;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [1:0]              digit_sel;
    logic [3:0]              digit_c;
    logic [AN_W-1:0]         an_q, an_d;
    logic [SEG_W-1:0]        seg_q, seg_d;

`ifdef ALU_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [NBTN-1:0]           db_q, db_d;
    logic [NBTN-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;

    // A new synchronized level must persist DEBOUNCE_CYCLES cycles before it is accepted.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < int'(NBTN); i++) begin
            if (sync2_q[i] == db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d[i]     = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            db_q     <= '0;
            db_cnt_q <= '0;
        end else begin
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign btn_lvl = db_q;
`else
    assign btn_lvl = sync2_q;
`endif

    // Register loads and the ALU; result always follows the current A, B and opcode.
    always_comb begin
        btn_rise = btn_lvl & ~lvl_prev_q;
        a_d      = btn_rise[BTN_A]  ? sw             : a_q;
        b_d      = btn_rise[BTN_B]  ? sw             : b_q;
        op_d     = btn_rise[BTN_OP] ? sw[OP_W-1:0]   : op_q;

        alu_wide = '0;
        case (op_q)
            OP_ADD: alu_wide = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB: alu_wide = {1'b0, a_q} - {1'b0, b_q};
            OP_AND: alu_wide = {1'b0, a_q & b_q};
            OP_OR:  alu_wide = {1'b0, a_q | b_q};
            OP_XOR: alu_wide = {1'b0, a_q ^ b_q};
            OP_NOT: alu_wide = {1'b0, ~a_q};
            OP_SHL: alu_wide = {a_q, 1'b0};
            OP_SHR: alu_wide = {a_q[0], 1'b0, a_q[DATA_W-1:1]};
        endcase
        result_d = alu_wide[DATA_W-1:0];
        carry_d  = alu_wide[DATA_W];
    end

    // Display is built from next-state values so anode and segments stay aligned with the counter.
    always_comb begin
        refresh_d = refresh_q + REFRESH_BITS'(1);
        digit_sel = refresh_d[REFRESH_BITS-1 -: 2];
        digit_c   = '0;
        case (digit_sel)
            2'd0: digit_c = result_d[3:0];
            2'd1: digit_c = result_d[7:4];
            2'd2: digit_c = {3'b000, carry_d};
            2'd3: digit_c = {1'b0, op_d};
        endcase
        an_d = AN_PAT[digit_sel];
    end

    seven_seg_decoder u_seg_dec (
        .hex_i (digit_c),
        .seg_o (seg_d)
    );

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_prev_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            refresh_q  <= '0;
            an_q       <= AN_PAT[0];
            seg_q      <= SEG_HEX[0];
        end else begin
            sync1_q    <= {pb_op, pb_b, pb_a};
            sync2_q    <= sync1_q;
            lvl_prev_q <= btn_lvl;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            refresh_q  <= refresh_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign LED           = result_q;
    assign AN_SEL        = an_q;
    assign seven_seg_out = seg_q;

endmodule

// File: tb/tb_alu_top.sv
// Directed self-checking bench for alu_top, built with a 4-bit refresh counter.
module tb_alu_top;

    logic       Clk   = 1'b0;
    logic       reset = 1'b0;
    logic       pb_a  = 1'b0;
    logic       pb_b  = 1'b0;
    logic       pb_op = 1'b0;
    logic [7:0] sw    = 8'h00;
    logic [7:0] LED;
    logic [3:0] AN_SEL;
    logic [6:0] seven_seg_out;

    int checks = 0;
    int errors = 0;

    logic [3:0] tb_cnt;

    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [3:0] ANS [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    alu_top #(.REFRESH_BITS(4)) dut (
        .Clk           (Clk),
        .reset         (reset),
        .pb_a          (pb_a),
        .pb_b          (pb_b),
        .pb_op         (pb_op),
        .sw            (sw),
        .LED           (LED),
        .AN_SEL        (AN_SEL),
        .seven_seg_out (seven_seg_out)
    );

    always #5 Clk = ~Clk;

    // Reference refresh counter, reset with the DUT.
    always @(posedge Clk or negedge reset) begin
        if (!reset) tb_cnt <= 4'd0;
        else        tb_cnt <= tb_cnt + 4'd1;
    end

    // mask bit0 = pb_a, bit1 = pb_b, bit2 = pb_op
    task automatic press(input logic [2:0] mask, input logic [7:0] val);
        @(posedge Clk); #1;
        sw = val;
        {pb_op, pb_b, pb_a} = mask;
        repeat (5) @(posedge Clk);
        #1;
        {pb_op, pb_b, pb_a} = 3'b000;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
    endtask

    // Records the segment pattern shown under each anode over one full refresh period.
    task automatic capture_display(output logic [6:0] d0, output logic [6:0] d1,
                                   output logic [6:0] d2, output logic [6:0] d3);
        d0 = 7'h7F; d1 = 7'h7F; d2 = 7'h7F; d3 = 7'h7F;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            case (AN_SEL)
                4'b1110: d0 = seven_seg_out;
                4'b1101: d1 = seven_seg_out;
                4'b1011: d2 = seven_seg_out;
                4'b0111: d3 = seven_seg_out;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (25) @(posedge Clk);
        @(negedge Clk);
        reset = 1'b1;
        #1;
        checks++;
        if (LED !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", LED); end
        checks++;
        if (AN_SEL !== 4'b1110) begin errors++; $display("FAIL reset_an: got %b expected 1110", AN_SEL); end
        checks++;
        if (seven_seg_out !== 7'b1000000) begin errors++; $display("FAIL reset_seg: got %b expected 1000000", seven_seg_out); end
    endtask

    task automatic test_sub();
        logic [6:0] d0, d1, d2, d3;
        press(3'b001, 8'h0F);
        press(3'b010, 8'h05);
        press(3'b100, 8'h01);
        checks++;
        if (LED !== 8'h0A) begin errors++; $display("FAIL sub_led: got %h expected 0a", LED); end
        capture_display(d0, d1, d2, d3);
        checks++;
        if (d0 !== SEG[10]) begin errors++; $display("FAIL sub_digit0: got %b expected %b", d0, SEG[10]); end
        checks++;
        if (d1 !== SEG[0]) begin errors++; $display("FAIL sub_digit1: got %b expected %b", d1, SEG[0]); end
        checks++;
        if (d2 !== SEG[0]) begin errors++; $display("FAIL sub_carry: got %b expected %b", d2, SEG[0]); end
        checks++;
        if (d3 !== SEG[1]) begin errors++; $display("FAIL sub_opcode: got %b expected %b", d3, SEG[1]); end
    endtask

    task automatic test_add();
        logic [6:0] d0, d1, d2, d3;
        press(3'b100, 8'h00);
        checks++;
        if (LED !== 8'h14) begin errors++; $display("FAIL add_led: got %h expected 14", LED); end
        press(3'b001, 8'hFF);
        press(3'b010, 8'h01);
        checks++;
        if (LED !== 8'h00) begin errors++; $display("FAIL add_wrap_led: got %h expected 00", LED); end
        capture_display(d0, d1, d2, d3);
        checks++;
        if (d2 !== SEG[1]) begin errors++; $display("FAIL add_carry: got %b expected %b", d2, SEG[1]); end
        checks++;
        if (d3 !== SEG[0]) begin errors++; $display("FAIL add_opcode: got %b expected %b", d3, SEG[0]); end
    endtask

    task automatic test_borrow_and();
        logic [6:0] d0, d1, d2, d3;
        press(3'b001, 8'h05);
        press(3'b010, 8'h0F);
        press(3'b100, 8'h01);
        checks++;
        if (LED !== 8'hF6) begin errors++; $display("FAIL borrow_led: got %h expected f6", LED); end
        capture_display(d0, d1, d2, d3);
        checks++;
        if (d2 !== SEG[1]) begin errors++; $display("FAIL borrow_carry: got %b expected %b", d2, SEG[1]); end
        checks++;
        if (d1 !== SEG[15]) begin errors++; $display("FAIL borrow_digit1: got %b expected %b", d1, SEG[15]); end
        checks++;
        if (d0 !== SEG[6]) begin errors++; $display("FAIL borrow_digit0: got %b expected %b", d0, SEG[6]); end
        press(3'b001, 8'h0F);
        press(3'b010, 8'h05);
        press(3'b100, 8'h02);
        checks++;
        if (LED !== 8'h05) begin errors++; $display("FAIL and_led: got %h expected 05", LED); end
        capture_display(d0, d1, d2, d3);
        checks++;
        if (d2 !== SEG[0]) begin errors++; $display("FAIL and_carry: got %b expected %b", d2, SEG[0]); end
    endtask

    task automatic test_ops();
        logic [6:0] d0, d1, d2, d3;
        logic [2:0] ops  [5] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [7:0] res  [5] = '{8'h9F, 8'h99, 8'h69, 8'h2C, 8'h4B};
        logic [3:0] cy   [5] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
        press(3'b001, 8'h96);
        press(3'b010, 8'h0F);
        for (int i = 0; i < 5; i++) begin
            press(3'b100, {5'b00000, ops[i]});
            checks++;
            if (LED !== res[i]) begin errors++; $display("FAIL op%0d_led: got %h expected %h", ops[i], LED, res[i]); end
            capture_display(d0, d1, d2, d3);
            checks++;
            if (d2 !== SEG[cy[i]]) begin errors++; $display("FAIL op%0d_carry: got %b expected %b", ops[i], d2, SEG[cy[i]]); end
        end
        press(3'b001, 8'h81);
        checks++;
        if (LED !== 8'h40) begin errors++; $display("FAIL shr_lsb_led: got %h expected 40", LED); end
        capture_display(d0, d1, d2, d3);
        checks++;
        if (d2 !== SEG[1]) begin errors++; $display("FAIL shr_lsb_carry: got %b expected %b", d2, SEG[1]); end
    endtask

    task automatic test_no_effect();
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #1;
            sw = 8'(i * 37 + 5);
        end
        repeat (6) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (LED !== 8'h40) begin errors++; $display("FAIL idle_switches: got %h expected 40", LED); end
    endtask

    task automatic test_latency();
        press(3'b010, 8'hFF);
        press(3'b100, 8'h02);
        checks++;
        if (LED !== 8'h81) begin errors++; $display("FAIL latency_setup: got %h expected 81", LED); end
        @(posedge Clk); #1;
        sw   = 8'h5A;
        pb_a = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (LED !== 8'h81) begin errors++; $display("FAIL latency_early: got %h expected 81", LED); end
        @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (LED !== 8'h5A) begin errors++; $display("FAIL latency_result: got %h expected 5a", LED); end
        pb_a = 1'b0;
        repeat (4) @(posedge Clk);
    endtask

    task automatic test_hold();
        @(posedge Clk); #1;
        sw   = 8'h3C;
        pb_a = 1'b1;
        repeat (4) @(posedge Clk);
        for (int i = 0; i < 100; i++) begin
            #1;
            sw = 8'hC3 ^ 8'(i);
            @(posedge Clk);
        end
        @(negedge Clk);
        checks++;
        if (LED !== 8'h3C) begin errors++; $display("FAIL hold_during: got %h expected 3c", LED); end
        pb_a = 1'b0;
        repeat (6) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (LED !== 8'h3C) begin errors++; $display("FAIL hold_after: got %h expected 3c", LED); end
    endtask

    task automatic test_simultaneous();
        press(3'b100, 8'h00);
        press(3'b011, 8'h77);
        checks++;
        if (LED !== 8'hEE) begin errors++; $display("FAIL simul_ab: got %h expected ee", LED); end
        press(3'b111, 8'h03);
        checks++;
        if (LED !== 8'h03) begin errors++; $display("FAIL simul_all: got %h expected 03", LED); end
    endtask

    // State here: result 0x03, carry 0, opcode 3 -> digits 3,0,0,3.
    task automatic test_display();
        logic [3:0] exp_d [4] = '{4'h3, 4'h0, 4'h0, 4'h3};
        logic [1:0] idx;
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            idx = tb_cnt[3:2];
            checks++;
            if (AN_SEL !== ANS[idx]) begin errors++; $display("FAIL disp_an cnt=%0d: got %b expected %b", tb_cnt, AN_SEL, ANS[idx]); end
            checks++;
            if (seven_seg_out !== SEG[exp_d[idx]]) begin errors++; $display("FAIL disp_seg cnt=%0d: got %b expected %b", tb_cnt, seven_seg_out, SEG[exp_d[idx]]); end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge Clk); #1;
        sw   = 8'hAA;
        pb_a = 1'b1;
        @(posedge Clk); #3;
        reset = 1'b0;
        #1;
        checks++;
        if (LED !== 8'h00) begin errors++; $display("FAIL midreset_led: got %h expected 00", LED); end
        checks++;
        if (AN_SEL !== 4'b1110) begin errors++; $display("FAIL midreset_an: got %b expected 1110", AN_SEL); end
        checks++;
        if (seven_seg_out !== 7'b1000000) begin errors++; $display("FAIL midreset_seg: got %b expected 1000000", seven_seg_out); end
        pb_a = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        reset = 1'b1;
        repeat (8) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (LED !== 8'h00) begin errors++; $display("FAIL midreset_after: got %h expected 00", LED); end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_add();
        test_borrow_and();
        test_ops();
        test_no_effect();
        test_latency();
        test_hold();
        test_simultaneous();
        test_display();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
